// File: rtl/crdma_pkg.sv
// Shared definitions for the column DMA micro-controller: instruction field
// layout, mode encodings, FSM state encoding and the completion code.
package crdma_pkg;

  // Instruction field layout (bit offsets and widths)
  localparam int INST_ID_LSB   = 28;
  localparam int INST_ID_W     = 4;
  localparam int INST_MASK_LSB = 20;
  localparam int INST_MASK_W   = 8;
  localparam int INST_MODE_LSB = 16;
  localparam int INST_MODE_W   = 4;
  localparam int INST_N_LSB    = 0;
  localparam int INST_N_W      = 16;

  // Mode field encodings; any other value behaves as SKIP
  localparam logic [3:0] MODE_PASS  = 4'd0;
  localparam logic [3:0] MODE_SKIP  = 4'd1;
  localparam logic [3:0] MODE_BCAST = 4'd2;

  // Code placed in the mode field of the completion word
  localparam logic [3:0] DONE_CODE = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FWD  = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    OP_PASS  = 2'd0,
    OP_SKIP  = 2'd1,
    OP_BCAST = 2'd2
  } op_e;

  // Collapse the 4-bit mode field into the three supported operations
  function automatic op_e decode_mode(input logic [3:0] mode);
    op_e op;
    case (mode)
      MODE_PASS:  op = OP_PASS;
      MODE_BCAST: op = OP_BCAST;
      default:    op = OP_SKIP;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/crdma_skid.sv
// Two-entry per-channel output buffer. Registered output, so a beat pushed
// in one cycle is visible the next; accepts a new beat whenever not full,
// which sustains one beat per cycle while the consumer keeps up.
module crdma_skid #(
  parameter int W = 66
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_data_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  output logic [W-1:0] out_data_o,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic         empty_o
);

  logic [W-1:0] mem0_q, mem0_d;
  logic [W-1:0] mem1_q, mem1_d;
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         push;
  logic         pop;

  assign in_ready_o  = (cnt_q != 2'd2);
  assign out_valid_o = (cnt_q != 2'd0);
  assign empty_o     = (cnt_q == 2'd0);
  assign out_data_o  = rd_ptr_q ? mem1_q : mem0_q;
  assign push        = in_valid_i & in_ready_o;
  assign pop         = out_valid_o & out_ready_i;

  // Next-state for storage, pointers and occupancy
  always_comb begin
    mem0_d   = mem0_q;
    mem1_d   = mem1_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      if (wr_ptr_q) mem1_d = in_data_i;
      else          mem0_d = in_data_i;
      wr_ptr_d = ~wr_ptr_q;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Buffer registers; reset drops any held beats
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem0_q   <= '0;
      mem1_q   <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      mem0_q   <= mem0_d;
      mem1_q   <= mem1_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/crdma_mc.sv
// Column DMA micro-controller. Consumes instructions; foreign-id words are
// forwarded untouched, own-id words move N column beats per masked channel
// (PASS / SKIP / BCAST), regenerate first/last framing, and finish with a
// completion word on the instruction output.
//
// Handshakes: every stream transfers a word on a rising clock edge where
// valid and ready are both 1. A source holds valid and data stable until
// the transfer; ready never depends combinationally on the same stream's valid.
module crdma_mc
  import crdma_pkg::*;
#(
  parameter int         DW  = 64,
  parameter int         IW  = 32,
  parameter int         NCH = 2,
  parameter logic [3:0] ID  = 4'h0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IW-1:0]     inst_m_data,
  input  logic              inst_m_valid,
  output logic              inst_m_ready,
  output logic [IW-1:0]     inst_s_data,
  output logic              inst_s_valid,
  input  logic              inst_s_ready,
  input  logic [NCH*DW-1:0] clm_m_data,
  input  logic [NCH-1:0]    clm_m_first,
  input  logic [NCH-1:0]    clm_m_last,
  input  logic [NCH-1:0]    clm_m_valid,
  output logic [NCH-1:0]    clm_m_ready,
  output logic [NCH*DW-1:0] clm_s_data,
  output logic [NCH-1:0]    clm_s_first,
  output logic [NCH-1:0]    clm_s_last,
  output logic [NCH-1:0]    clm_s_valid,
  input  logic [NCH-1:0]    clm_s_ready,
  output logic              busy,
  output logic              err,
  output state_e            dbg_state_o
);

  state_e state_q, state_d;

  logic [IW-1:0]               inst_q, inst_d;
  logic [INST_MASK_W-1:0]      mask8_q, mask8_d;
  op_e                         op_q, op_d;
  logic [15:0]                 n_q, n_d;
  logic [NCH-1:0][15:0]        cnt_q, cnt_d;
  logic                        err_q, err_d;

  logic                        inst_acc;
  logic                        inst_own;
  logic [NCH-1:0]              new_mask;
  logic [15:0]                 new_n;

  logic                        run;
  logic                        is_pass;
  logic                        is_bcast;
  logic [NCH-1:0]              eff_mask;
  logic [15:0]                 n_last;

  logic [NCH-1:0]              sk_in_ready;
  logic [NCH-1:0]              sk_push;
  logic [NCH-1:0]              sk_empty;
  logic [NCH-1:0]              sk_out_valid;
  logic [NCH-1:0][DW+1:0]      sk_in_data;
  logic [NCH-1:0][DW+1:0]      sk_out_data;

  logic [NCH-1:0]              adv;
  logic                        bc_ok;
  logic [15:0]                 bc_cnt;
  logic                        frame_err;
  logic                        all_done;

  assign inst_acc = inst_m_valid & inst_m_ready;
  assign inst_own = (inst_m_data[INST_ID_LSB +: INST_ID_W] == ID);
  assign new_mask = inst_m_data[INST_MASK_LSB +: NCH];
  assign new_n    = inst_m_data[INST_N_LSB +: INST_N_W];

  assign run      = (state_q == ST_RUN);
  assign is_pass  = (op_q == OP_PASS);
  assign is_bcast = (op_q == OP_BCAST);
  assign eff_mask = mask8_q[NCH-1:0];
  assign n_last   = n_q - 16'd1;

  assign err         = err_q;
  assign dbg_state_o = state_q;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state: own-id work runs only with a non-empty mask and N != 0
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (inst_acc) begin
          if (!inst_own)                            state_d = ST_FWD;
          else if (new_n != 16'd0 && new_mask != '0) state_d = ST_RUN;
          else                                       state_d = ST_DONE;
        end
      end
      ST_FWD:  if (inst_s_ready) state_d = ST_IDLE;
      ST_RUN:  if (all_done)     state_d = ST_DONE;
      ST_DONE: if (inst_s_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: instruction handshakes, forwarded word or completion word
  always_comb begin
    inst_m_ready = (state_q == ST_IDLE) && !rst;
    inst_s_valid = 1'b0;
    inst_s_data  = '0;
    busy         = (state_q != ST_IDLE);
    case (state_q)
      ST_FWD: begin
        inst_s_valid = 1'b1;
        inst_s_data  = inst_q;
      end
      ST_DONE: begin
        inst_s_valid      = 1'b1;
        inst_s_data[31:0] = {ID, mask8_q, DONE_CODE, n_q};
      end
      default: ;
    endcase
  end

  // Column steering: per-channel accept, counter advance, buffer push and
  // framing check. BCAST gates channel 0 on every masked buffer having room.
  always_comb begin
    clm_m_ready = '0;
    sk_push     = '0;
    adv         = '0;
    sk_in_data  = '0;
    frame_err   = 1'b0;
    bc_ok       = run && is_bcast;
    bc_cnt      = '0;
    // Descending scan so the lowest masked channel supplies the shared count
    for (int i = NCH - 1; i >= 0; i--) begin
      if (eff_mask[i]) begin
        bc_cnt = cnt_q[i];
        if (!sk_in_ready[i] || cnt_q[i] >= n_q) bc_ok = 1'b0;
      end
    end
    for (int i = 0; i < NCH; i++) begin
      if (is_bcast)
        sk_in_data[i] = {cnt_q[i] == 16'd0, cnt_q[i] == n_last, clm_m_data[0 +: DW]};
      else
        sk_in_data[i] = {cnt_q[i] == 16'd0, cnt_q[i] == n_last, clm_m_data[i*DW +: DW]};
      if (run && eff_mask[i]) begin
        if (is_bcast) begin
          adv[i]     = bc_ok & clm_m_valid[0];
          sk_push[i] = adv[i];
        end else begin
          clm_m_ready[i] = (cnt_q[i] < n_q) && (!is_pass || sk_in_ready[i]);
          adv[i]         = clm_m_ready[i] & clm_m_valid[i];
          sk_push[i]     = adv[i] & is_pass;
          if (adv[i] && ((clm_m_first[i] && cnt_q[i] != 16'd0) ||
                         (clm_m_last[i]  && cnt_q[i] != n_last)))
            frame_err = 1'b1;
        end
      end
    end
    if (bc_ok) begin
      clm_m_ready[0] = 1'b1;
      if (clm_m_valid[0] && ((clm_m_first[0] && bc_cnt != 16'd0) ||
                             (clm_m_last[0]  && bc_cnt != n_last)))
        frame_err = 1'b1;
    end
  end

  // Completion condition: masked counters at N and every buffer drained
  always_comb begin
    all_done = 1'b1;
    for (int i = 0; i < NCH; i++) begin
      if (eff_mask[i] && cnt_q[i] != n_q) all_done = 1'b0;
      if (!sk_empty[i])                   all_done = 1'b0;
    end
  end

  // Datapath next-state: latch instruction fields, advance counters, sticky err
  always_comb begin
    inst_d  = inst_q;
    mask8_d = mask8_q;
    op_d    = op_q;
    n_d     = n_q;
    cnt_d   = cnt_q;
    err_d   = err_q | frame_err;
    if (inst_acc) begin
      if (inst_own) begin
        mask8_d = inst_m_data[INST_MASK_LSB +: INST_MASK_W];
        op_d    = decode_mode(inst_m_data[INST_MODE_LSB +: INST_MODE_W]);
        n_d     = new_n;
        cnt_d   = '0;
      end else begin
        inst_d  = inst_m_data;
      end
    end else begin
      for (int i = 0; i < NCH; i++)
        if (adv[i]) cnt_d[i] = cnt_q[i] + 16'd1;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inst_q  <= '0;
      mask8_q <= '0;
      op_q    <= OP_PASS;
      n_q     <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      inst_q  <= inst_d;
      mask8_q <= mask8_d;
      op_q    <= op_d;
      n_q     <= n_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // One output buffer per channel; payload is {first, last, data}
  for (genvar g = 0; g < NCH; g++) begin : g_ch
    crdma_skid #(.W(DW + 2)) u_skid (
      .clk         (clk),
      .rst         (rst),
      .in_data_i   (sk_in_data[g]),
      .in_valid_i  (sk_push[g]),
      .in_ready_o  (sk_in_ready[g]),
      .out_data_o  (sk_out_data[g]),
      .out_valid_o (sk_out_valid[g]),
      .out_ready_i (clm_s_ready[g]),
      .empty_o     (sk_empty[g])
    );
    assign clm_s_data[g*DW +: DW] = sk_out_data[g][DW-1:0];
    assign clm_s_last[g]          = sk_out_data[g][DW];
    assign clm_s_first[g]         = sk_out_data[g][DW+1];
    assign clm_s_valid[g]         = sk_out_valid[g];
  end

endmodule
